int32_requant_pack: RTL and testbench

Requantization and packing stage on the output side of the int8 MAC array. It accepts signed 32-bit accumulator results on a valid/ready stream and scales each one by a per-layer multiplier and right shift. Each result is rounded, offset by a zero point, saturated to int8, and four lanes are packed into a 32-bit word for write-back to activation memory. It is the int32-to-int8 path that mirrors the MAC's int8-to-int32 path.

---
 rtl/int32_requant_pack.sv | 167 ++++++++++++++++
 tb/tb_int32_requant_pack.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/int32_requant_pack.sv
// Requantizes signed int32 accumulator beats to int8 (scale, rounding shift, zero point, clamp)
// and packs four lanes per 32-bit output word, with a tail flush on in_last.
module int32_requant_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_scale,
    input  logic [4:0]  cfg_shift,
    input  logic [7:0]  cfg_zp,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_acc,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic [15:0] sat_count
);

    logic               en;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_last_q, s1_last_d;
    logic [47:0]        s1_prod_q, s1_prod_d;

    logic               s2_valid_q, s2_valid_d;
    logic               s2_last_q, s2_last_d;
    logic               s2_sat_q, s2_sat_d;
    logic [7:0]         s2_byte_q, s2_byte_d;

    logic [1:0]         lane_q, lane_d;
    logic [31:0]        part_data_q, part_data_d;
    logic [3:0]         part_keep_q, part_keep_d;

    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [3:0]         out_keep_q, out_keep_d;
    logic               out_last_q, out_last_d;
    logic [15:0]        sat_count_q, sat_count_d;

    logic [47:0]        acc_ext, scale_ext;
    logic signed [48:0] prod_ext, rnd_add, r_val, zp_ext, v_val;
    logic               sat_hi, sat_lo;
    logic [31:0]        merged_data;
    logic [3:0]         merged_keep;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign sat_count = sat_count_q;

    // Stage 1: sign-extend both operands so the low 48 bits of the product are the signed result.
    always_comb begin
        acc_ext    = {{16{in_acc[31]}}, in_acc};
        scale_ext  = {{32{cfg_scale[15]}}, cfg_scale};
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_prod_d  = s1_prod_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_last_d  = in_last;
            s1_prod_d  = acc_ext * scale_ext;
        end
    end

    // Stage 2: round half toward +inf, add zero point, clamp to int8.
    always_comb begin
        prod_ext   = {s1_prod_q[47], s1_prod_q};
        rnd_add    = (cfg_shift == 5'd0) ? 49'sd0 : (49'sd1 <<< (cfg_shift - 5'd1));
        r_val      = (prod_ext + rnd_add) >>> cfg_shift;
        zp_ext     = {{41{cfg_zp[7]}}, cfg_zp};
        v_val      = r_val + zp_ext;
        sat_hi     = v_val > 49'sd127;
        sat_lo     = v_val < -49'sd128;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_sat_d   = s2_sat_q;
        s2_byte_d  = s2_byte_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_sat_d   = sat_hi || sat_lo;
            s2_byte_d  = sat_hi ? 8'h7F : (sat_lo ? 8'h80 : v_val[7:0]);
        end
    end

    always_comb begin
        merged_data = part_data_q;
        merged_data[{lane_q, 3'b000} +: 8] = s2_byte_q;
        merged_keep = part_keep_q;
        merged_keep[lane_q] = 1'b1;

        lane_d      = lane_q;
        part_data_d = part_data_q;
        part_keep_d = part_keep_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        sat_count_d = sat_count_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A loading word overrides the drain above, so a held word can be replaced in one cycle.
        if (en && s2_valid_q) begin
            if (lane_q == 2'd3 || s2_last_q) begin
                out_valid_d = 1'b1;
                out_data_d  = merged_data;
                out_keep_d  = merged_keep;
                out_last_d  = s2_last_q;
                lane_d      = 2'd0;
                part_data_d = 32'h0;
                part_keep_d = 4'h0;
            end else begin
                lane_d      = lane_q + 2'd1;
                part_data_d = merged_data;
                part_keep_d = merged_keep;
            end
            if (s2_sat_q && sat_count_q != 16'hFFFF) begin
                sat_count_d = sat_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= 48'h0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sat_q    <= 1'b0;
            s2_byte_q   <= 8'h0;
            lane_q      <= 2'd0;
            part_data_q <= 32'h0;
            part_keep_q <= 4'h0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_keep_q  <= 4'h0;
            out_last_q  <= 1'b0;
            sat_count_q <= 16'h0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_sat_q    <= s2_sat_d;
            s2_byte_q   <= s2_byte_d;
            lane_q      <= lane_d;
            part_data_q <= part_data_d;
            part_keep_q <= part_keep_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            sat_count_q <= sat_count_d;
        end
    end

endmodule

// File: tb/tb_int32_requant_pack.sv
// Scoreboard bench for int32_requant_pack: directed beats push hand-computed words into a queue,
// and a negedge monitor pops and compares every accepted output word.
module tb_int32_requant_pack;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_scale = 16'd1;
    logic [4:0]  cfg_shift = 5'd0;
    logic [7:0]  cfg_zp = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = 32'h0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [15:0] sat_count;

    word_t exp_q[$];
    int    checks = 0;
    int    failures = 0;

    int32_requant_pack dut (
        .clk(clk), .rst(rst),
        .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Drives one beat and returns just after the posedge on which it was accepted.
    task automatic applyStimulus(input logic [31:0] acc, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_acc   = acc;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expectWord(input logic [31:0] data, input logic [3:0] keep, input logic last);
        word_t w;
        w.data = data;
        w.keep = keep;
        w.last = last;
        exp_q.push_back(w);
    endtask

    task automatic waitDrain();
        int waited = 0;
        while ((exp_q.size() != 0 || out_valid) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word accepted by the downstream side is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", out_data, 32'h0);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                checkOutput("word_data", out_data, w.data);
                checkOutput("word_keep", {28'h0, out_keep}, {28'h0, w.keep});
                checkOutput("word_last", {31'h0, out_last}, {31'h0, w.last});
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_in_ready", {31'h0, in_ready}, 32'd0);
        checkOutput("reset_out_valid", {31'h0, out_valid}, 32'd0);
        checkOutput("reset_out_data", out_data, 32'h0);
        checkOutput("reset_sat_count", {16'h0, sat_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] pass-through");
        expectWord(32'h807FFF01, 4'hF, 1'b1);
        applyStimulus(32'd1, 1'b0);
        applyStimulus(32'hFFFFFFFF, 1'b0);
        applyStimulus(32'd127, 1'b0);
        applyStimulus(32'hFFFFFF80, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        checkOutput("latency", 32'(n), 32'd3);
        waitDrain();
        checkOutput("sat_after_passthru", {16'h0, sat_count}, 32'd0);

        $display("[TB] rounding");
        cfg_scale = 16'd3;
        cfg_shift = 5'd2;
        expectWord(32'hFC05FC04, 4'hF, 1'b1);
        applyStimulus(32'd5, 1'b0);
        applyStimulus(32'hFFFFFFFB, 1'b0);
        applyStimulus(32'd6, 1'b0);
        applyStimulus(32'hFFFFFFFA, 1'b1);
        waitDrain();
        checkOutput("sat_after_round", {16'h0, sat_count}, 32'd0);

        $display("[TB] saturation and zero point");
        cfg_scale = 16'd1;
        cfg_shift = 5'd0;
        cfg_zp    = 8'd10;
        expectWord(32'h807F807F, 4'hF, 1'b0);
        applyStimulus(32'd200, 1'b0);
        applyStimulus(32'hFFFFFED4, 1'b0);
        applyStimulus(32'd117, 1'b0);
        applyStimulus(32'hFFFFFF76, 1'b0);
        waitDrain();
        checkOutput("sat_after_clamp", {16'h0, sat_count}, 32'd2);

        $display("[TB] partial flush");
        cfg_zp = 8'd0;
        expectWord(32'h00000302, 4'h3, 1'b1);
        expectWord(32'h00000009, 4'h1, 1'b1);
        applyStimulus(32'd2, 1'b0);
        applyStimulus(32'd3, 1'b1);
        applyStimulus(32'd9, 1'b1);
        waitDrain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        expectWord(32'h04030201, 4'hF, 1'b0);
        expectWord(32'h08070605, 4'hF, 1'b0);
        expectWord(32'h0C0B0A09, 4'hF, 1'b0);
        fork
            begin
                for (int k = 1; k <= 12; k++) applyStimulus(32'(k), 1'b0);
            end
            begin
                repeat (10) @(negedge clk);
                checkOutput("bp_in_ready", {31'h0, in_ready}, 32'd0);
                checkOutput("bp_out_valid", {31'h0, out_valid}, 32'd1);
                checkOutput("bp_held_data", out_data, 32'h04030201);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] reset mid-word");
        applyStimulus(32'd5, 1'b0);
        applyStimulus(32'd6, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in_ready", {31'h0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", {31'h0, out_valid}, 32'd0);
        checkOutput("midrst_out_data", out_data, 32'h0);
        checkOutput("midrst_out_keep", {28'h0, out_keep}, 32'd0);
        checkOutput("midrst_sat_count", {16'h0, sat_count}, 32'd0);
        @(posedge clk);
        #1;
        expectWord(32'h04030201, 4'hF, 1'b0);
        for (int k = 1; k <= 4; k++) applyStimulus(32'(k), 1'b0);
        waitDrain();

        checkOutput("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
